nnp_responder: RTL and testbench
================================

# nnp_responder

Responder end of the 96 MHz NNP request/acknowledge interface. It accepts one request at a time from the algorithm controller, acknowledges it, and evaluates a small signed fixed-point linear layer (three outputs, each from three inputs plus a bias) with one time-shared multiplier. It returns three 16-bit results with a single-cycle valid pulse. Weights live in an internal 24-entry register file, writable from the same clock domain.

## Interface
Parameters:
- WID_8, 8, width of nnp_type
- WID_16, 16, data, weight and result width (Q8.8 signed)
- WID_ACC, 36, accumulator width

Ports:
- clk  in  1  96 MHz clock
- rst  in  1  reset rst, synchronous, active-high
- nnp_req  in  1  request level, held by the initiator until it samples nnp_ack
- nnp_ack  out  1  one-cycle acknowledge; request operands latched this cycle
- nnp_type  in  8  operation type; 1 and 2 supported
- req_data1/2/3  in  16 each  operands x0..x2, Q8.8 signed
- nnp_vld  out  1  one-cycle result strobe
- res_data1/2/3  out  16 each  results y0..y2, valid only while nnp_vld=1, otherwise 0
- nnp_err  out  1  pulses with nnp_vld for an unsupported type
- wgt_we  in  1  weight write strobe
- wgt_addr  in  5  {type-1 (1b), k (2b), j (2b)}; j=3 is the bias, j=0..2 are weights
- wgt_data  in  16  Q8.8 signed
- wgt_drop  out  1  one-cycle pulse when a write is rejected

## Operation
- States:
  - IDLE: wait for the arm condition and req.
  - LOAD: latch type and operands, assert ack.
  - MAC: 9 multiply-accumulate steps.
  - ROUND: round and saturate.
  - DONE: assert vld, then return to IDLE.
- Arm condition: after each ack, the block re-arms only after it samples nnp_req=0 at least once. A requester that holds req high therefore gets exactly one ack per request.
- IDLE→LOAD when armed and nnp_req=1. LOAD lasts 1 cycle. MAC runs a fixed number of cycles, then ROUND takes 1 cycle, then DONE takes 1 cycle, then the block returns to IDLE.
- Arithmetic, per output k:
  - acc_k = (bias_k sign-extended, <<8) + Σ_j W[t][k][j]·x_j.
  - Products are 16x16 signed (32-bit, Q16.16); acc_k is 36-bit signed.
  - y_k = (acc_k + 128) >>> 8, then reduced to 16 bits per Configuration.
- Unsupported type (0 or 3..255): the block still acks and runs for the same latency. At DONE it drives res_data*=0, nnp_vld=1, nnp_err=1.
- Weight writes: applied only in IDLE, taking effect the next cycle. In any other state the write is dropped and wgt_drop pulses.
- Reset contents: W[t][k][j] = 0x0100 for k==j, else 0; all biases 0. Default behaviour is an identity pass-through for both types.
- Reset values: nnp_ack=0, nnp_vld=0, nnp_err=0, res_data*=0, wgt_drop=0, state=IDLE, armed=1.

## Timing
- nnp_req sampled 1 in IDLE at cycle R → nnp_ack=1 at cycle A=R+1; operands and type are captured at A.
- Initiator-driven req may still read 1 at A+1. It is ignored because the block is no longer in IDLE.
- MAC: product issue A+1..A+9, accumulate A+2..A+10. ROUND at A+11. nnp_vld=1 at A+12 for exactly one cycle, with res_data* valid.
- Back in IDLE at A+13. The earliest next ack is A+14, provided req was seen low since A.
- Changes on operand inputs after A do not affect the current result.
- rst at any cycle: the block enters IDLE the next cycle, the in-flight result is discarded with no nnp_vld, and weights return to their reset contents.
- A wgt_we in the same cycle as LOAD entry is dropped (wgt_drop=1).

## Configuration
- NNP_RESP_SAT_EN defined: y_k saturates to 0x7FFF / 0x8000 when the shifted accumulator is outside the signed 16-bit range.
- NNP_RESP_SAT_EN undefined: y_k takes the low 16 bits of the shifted accumulator (two's-complement wrap); no saturation logic is built.

## Test plan
- Reset weights, type 2, x=(0x0100, 0xFF00, 0x7FFF) → ack at R+1; at A+12: vld=1, res=(0x0100, 0xFF00, 0x7FFF), err=0.
- Write type-1 W[0]=(0x0080, 0x0080, 0), bias0=0x0100; type 1, x=(0x0200, 0x0400, 0) → res_data1=0x0400.
- Saturation: type 2, all W[k][j]=0x7FFF, x=0x7FFF each → res=0x7FFF with the macro defined; without the macro, the low 16 bits of the shifted accumulator. Repeat with x=0x8001 → 0x8000 when saturating.
- Type 5 → ack at R+1; at A+12: vld=1, err=1, res all 0.
- req held high for 40 cycles → exactly one ack and one vld. Drop req for 1 cycle and raise it again → second ack.
- Assert rst at A+5 → no vld, and identity weights restored. In a separate run, a wgt_we during MAC → wgt_drop=1 and a subsequent identity check passes.

Source files
------------

// File: rtl/nnp_responder.sv
// nnp_responder: responder end of the NNP request/acknowledge interface.
// Accepts one request at a time, acknowledges it, and evaluates a signed
// Q8.8 linear layer y_k = bias_k + sum_j W[t][k][j] * x_j (k, j = 0..2) with
// a single time-shared multiplier. Results are returned with a one-cycle
// valid strobe.
//
// Optional feature macro: NNP_RESP_SAT_EN
//   defined   -> results saturate to 0x7FFF / 0x8000
//   undefined -> results wrap (low 16 bits of the shifted accumulator)
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   nnp_req / nnp_ack     request level / one-cycle acknowledge
//   nnp_type              operation type (1 and 2 supported)
//   req_data1..3          operands x0..x2 (Q8.8 signed)
//   nnp_vld, nnp_err      result strobe, unsupported-type flag
//   res_data1..3          results y0..y2 (zero unless nnp_vld)
//   wgt_we/addr/data      weight register file write port
//   wgt_drop              pulse when a write arrives while busy
module nnp_responder #(
    parameter int WID_8   = 8,
    parameter int WID_16  = 16,
    parameter int WID_ACC = 36
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              nnp_req,
    output logic              nnp_ack,
    input  logic [WID_8-1:0]  nnp_type,
    input  logic [WID_16-1:0] req_data1,
    input  logic [WID_16-1:0] req_data2,
    input  logic [WID_16-1:0] req_data3,
    output logic              nnp_vld,
    output logic [WID_16-1:0] res_data1,
    output logic [WID_16-1:0] res_data2,
    output logic [WID_16-1:0] res_data3,
    output logic              nnp_err,
    input  logic              wgt_we,
    input  logic [4:0]        wgt_addr,
    input  logic [WID_16-1:0] wgt_data,
    output logic              wgt_drop
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        MAC   = 3'd2,
        ROUND = 3'd3,
        DONE  = 3'd4
    } state_t;

`ifdef NNP_RESP_SAT_EN
    localparam int SHF_W = WID_ACC - 8;
`else
    localparam int SHF_W = WID_16;
`endif

    state_t                  state_r;
    logic                    armed_r;
    logic                    t_r;
    logic                    bad_r;
    logic [WID_16-1:0]       x_r     [0:2];
    logic [1:0]              k_r;
    logic [1:0]              j_r;
    logic [3:0]              step_r;
    logic signed [2*WID_16-1:0] prod_r;
    logic [1:0]              prod_k_r;
    logic [WID_ACC-1:0]      acc_r   [0:2];
    logic [WID_16-1:0]       wgt_r   [0:1][0:2][0:3];
    logic                    ack_r;
    logic                    vld_r;
    logic                    err_r;
    logic                    drop_r;
    logic [WID_16-1:0]       res_r   [0:2];

    logic                    start_s;
    logic                    wr_ok_s;
    logic                    t_in_s;
    logic signed [WID_16-1:0] w_sel_s;
    logic signed [WID_16-1:0] x_sel_s;
    logic [SHF_W-1:0]        shf_s   [0:2];
    logic [WID_16-1:0]       y_s     [0:2];

`ifdef NNP_RESP_SAT_EN
    // Clamp a shifted accumulator to the signed 16-bit range.
    function automatic logic [WID_16-1:0] sat16(input logic [SHF_W-1:0] v);
        logic [SHF_W-WID_16:0] top_s;
        top_s = v[SHF_W-1:WID_16-1];
        if ((&top_s) || !(|top_s)) begin
            sat16 = v[WID_16-1:0];
        end else if (v[SHF_W-1]) begin
            sat16 = {1'b1, {(WID_16-1){1'b0}}};
        end else begin
            sat16 = {1'b0, {(WID_16-1){1'b1}}};
        end
    endfunction
`endif

    assign nnp_ack   = ack_r;
    assign nnp_vld   = vld_r;
    assign nnp_err   = err_r;
    assign wgt_drop  = drop_r;
    assign res_data1 = res_r[0];
    assign res_data2 = res_r[1];
    assign res_data3 = res_r[2];

    // Request start, write acceptance, multiplier operand select and rounding.
    always_comb begin
        start_s = (state_r == IDLE) && armed_r && nnp_req;
        // A write in the cycle that launches LOAD is rejected.
        wr_ok_s = (state_r == IDLE) && !start_s;
        t_in_s  = (nnp_type == WID_8'(2));
        w_sel_s = wgt_r[t_r][k_r][j_r];
        case (j_r)
            2'd0:    x_sel_s = x_r[0];
            2'd1:    x_sel_s = x_r[1];
            2'd2:    x_sel_s = x_r[2];
            default: x_sel_s = {WID_16{1'b0}};
        endcase
        // (acc + 128) >>> 8 equals (acc >>> 8) + acc[7].
        for (int k = 0; k < 3; k++) begin
            shf_s[k] = acc_r[k][8 +: SHF_W] + {{(SHF_W-1){1'b0}}, acc_r[k][7]};
`ifdef NNP_RESP_SAT_EN
            y_s[k] = sat16(shf_s[k]);
`else
            y_s[k] = shf_s[k];
`endif
        end
    end

    // Weight register file: identity weights and zero bias after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int t = 0; t < 2; t++) begin
                for (int k = 0; k < 3; k++) begin
                    for (int j = 0; j < 4; j++) begin
                        wgt_r[t][k][j] <= (k == j) ? 16'h0100 : 16'h0000;
                    end
                end
            end
        end else if (wgt_we && wr_ok_s && (wgt_addr[3:2] != 2'd3)) begin
            wgt_r[wgt_addr[4]][wgt_addr[3:2]][wgt_addr[1:0]] <= wgt_data;
        end else begin
            wgt_r <= wgt_r;
        end
    end

    // Handshake FSM with the multiply-accumulate datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= IDLE;
            armed_r  <= 1'b1;
            t_r      <= 1'b0;
            bad_r    <= 1'b0;
            k_r      <= 2'd0;
            j_r      <= 2'd0;
            step_r   <= 4'd0;
            prod_r   <= '0;
            prod_k_r <= 2'd0;
            ack_r    <= 1'b0;
            vld_r    <= 1'b0;
            err_r    <= 1'b0;
            drop_r   <= 1'b0;
            for (int k = 0; k < 3; k++) begin
                x_r[k]   <= '0;
                acc_r[k] <= '0;
                res_r[k] <= '0;
            end
        end else begin
            ack_r  <= 1'b0;
            vld_r  <= 1'b0;
            err_r  <= 1'b0;
            drop_r <= wgt_we && !wr_ok_s;
            for (int k = 0; k < 3; k++) begin
                res_r[k] <= '0;
            end
            // Seeing req low at any time re-arms for the next request.
            if (!nnp_req) begin
                armed_r <= 1'b1;
            end
            case (state_r)
                IDLE: begin
                    if (start_s) begin
                        state_r <= LOAD;
                        ack_r   <= 1'b1;
                        armed_r <= 1'b0;
                    end
                end
                LOAD: begin
                    t_r    <= t_in_s;
                    bad_r  <= !((nnp_type == WID_8'(1)) || (nnp_type == WID_8'(2)));
                    x_r[0] <= req_data1;
                    x_r[1] <= req_data2;
                    x_r[2] <= req_data3;
                    for (int k = 0; k < 3; k++) begin
                        acc_r[k] <= {{(WID_ACC-WID_16-8){wgt_r[t_in_s][k][3][WID_16-1]}},
                                     wgt_r[t_in_s][k][3], 8'h00};
                    end
                    k_r     <= 2'd0;
                    j_r     <= 2'd0;
                    step_r  <= 4'd0;
                    state_r <= MAC;
                end
                MAC: begin
                    // Steps 0..8 issue products; steps 1..9 accumulate the previous one.
                    if (step_r < 4'd9) begin
                        prod_r   <= w_sel_s * x_sel_s;
                        prod_k_r <= k_r;
                        if (j_r == 2'd2) begin
                            j_r <= 2'd0;
                            k_r <= k_r + 2'd1;
                        end else begin
                            j_r <= j_r + 2'd1;
                        end
                    end
                    if (step_r != 4'd0) begin
                        acc_r[prod_k_r] <= acc_r[prod_k_r] +
                            {{(WID_ACC-2*WID_16){prod_r[2*WID_16-1]}}, prod_r};
                    end
                    if (step_r == 4'd9) begin
                        state_r <= ROUND;
                    end
                    step_r <= step_r + 4'd1;
                end
                ROUND: begin
                    vld_r <= 1'b1;
                    err_r <= bad_r;
                    for (int k = 0; k < 3; k++) begin
                        res_r[k] <= bad_r ? {WID_16{1'b0}} : y_s[k];
                    end
                    state_r <= DONE;
                end
                DONE: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nnp_responder.sv
// Self-checking bench for nnp_responder. Expected results come from an
// arithmetic reference model of the linear layer kept in this file.
module tb_nnp_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        nnp_req = 1'b0;
    logic        nnp_ack;
    logic [7:0]  nnp_type = 8'd0;
    logic [15:0] req_data1 = 16'h0, req_data2 = 16'h0, req_data3 = 16'h0;
    logic        nnp_vld;
    logic [15:0] res_data1, res_data2, res_data3;
    logic        nnp_err;
    logic        wgt_we = 1'b0;
    logic [4:0]  wgt_addr = 5'd0;
    logic [15:0] wgt_data = 16'h0;
    logic        wgt_drop;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int w_m [0:1][0:2][0:3];

    nnp_responder dut (
        .clk(clk), .rst(rst),
        .nnp_req(nnp_req), .nnp_ack(nnp_ack), .nnp_type(nnp_type),
        .req_data1(req_data1), .req_data2(req_data2), .req_data3(req_data3),
        .nnp_vld(nnp_vld),
        .res_data1(res_data1), .res_data2(res_data2), .res_data3(res_data3),
        .nnp_err(nnp_err),
        .wgt_we(wgt_we), .wgt_addr(wgt_addr), .wgt_data(wgt_data),
        .wgt_drop(wgt_drop)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #300000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int t = 0; t < 2; t++)
            for (int k = 0; k < 3; k++)
                for (int j = 0; j < 4; j++)
                    w_m[t][k][j] = (k == j) ? 256 : 0;
    endfunction

    function automatic logic [15:0] model_y(input int t, input int k,
                                            input logic [15:0] a, b, c);
        longint acc, y;
        if (!(t == 1 || t == 2)) return 16'h0000;
        acc = longint'(w_m[t-1][k][3]) * 256
            + longint'(w_m[t-1][k][0]) * longint'($signed(a))
            + longint'(w_m[t-1][k][1]) * longint'($signed(b))
            + longint'(w_m[t-1][k][2]) * longint'($signed(c));
        y = (acc + 128) >>> 8;
`ifdef NNP_RESP_SAT_EN
        if (y > 32767) y = 32767;
        if (y < -32768) y = -32768;
`endif
        return y[15:0];
    endfunction

    task automatic wr(input logic [4:0] addr, input logic [15:0] data);
        @(negedge clk);
        wgt_we = 1'b1; wgt_addr = addr; wgt_data = data;
        @(posedge clk); #1;
        chk("idle_write_drop", wgt_drop, 1'b0);
        @(negedge clk);
        wgt_we = 1'b0;
        if (addr[3:2] != 2'd3) w_m[addr[4]][addr[3:2]][addr[1:0]] = int'($signed(data));
    endtask

    // One request. wr_off/rst_off (cycles after ack, 0 = none) inject a
    // weight write or a reset while the block is busy.
    task automatic run_req(input logic [7:0] t, input logic [15:0] a, b, c,
                           input int wr_off, input int rst_off,
                           output logic [15:0] y0, output logic [15:0] y1,
                           output logic [15:0] y2);
        logic [15:0] e0, e1, e2;
        logic        got, early, extra;
        int          start, a_cyc;
        e0 = model_y(int'(t), 0, a, b, c);
        e1 = model_y(int'(t), 1, a, b, c);
        e2 = model_y(int'(t), 2, a, b, c);
        @(negedge clk);
        nnp_type = t; req_data1 = a; req_data2 = b; req_data3 = c; nnp_req = 1'b1;
        start = cyc;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(posedge clk); #1;
            if (nnp_ack) got = 1'b1;
        end
        chk("ack_seen", got, 1'b1);
        chk("ack_latency", cyc - start, 1);
        a_cyc = cyc;
        early = 1'b0; extra = 1'b0;
        while (got && cyc < a_cyc + 12) begin
            @(negedge clk);
            if (cyc >= a_cyc + 1) begin
                nnp_req = 1'b0;
                req_data1 = 16'($urandom); req_data2 = 16'($urandom);
                req_data3 = 16'($urandom); nnp_type = 8'($urandom);
            end
            wgt_we = (wr_off != 0) && (cyc == a_cyc + wr_off);
            wgt_addr = 5'd1; wgt_data = 16'h1234;
            rst = (rst_off != 0) && (cyc == a_cyc + rst_off);
            @(posedge clk); #1;
            if (wgt_we) chk("busy_write_drop", wgt_drop, 1'b1);
            if (cyc < a_cyc + 12 && nnp_vld) early = 1'b1;
            if (nnp_ack) extra = 1'b1;
        end
        nnp_req = 1'b0;
        chk("no_early_vld", early, 1'b0);
        chk("no_extra_ack", extra, 1'b0);
        y0 = res_data1; y1 = res_data2; y2 = res_data3;
        if (rst_off == 0) begin
            chk("vld_at_A12", nnp_vld, 1'b1);
            chk("err", nnp_err, (t == 8'd1 || t == 8'd2) ? 1'b0 : 1'b1);
            chk("res_data1", res_data1, e0);
            chk("res_data2", res_data2, e1);
            chk("res_data3", res_data3, e2);
        end else begin
            chk("vld_after_rst", nnp_vld, 1'b0);
        end
        @(negedge clk);
        wgt_we = 1'b0; rst = 1'b0;
        @(posedge clk); #1;
        chk("vld_one_cycle", nnp_vld, 1'b0);
        chk("res_zero_idle", res_data1 | res_data2 | res_data3, 16'h0);
    endtask

    logic [15:0] y0, y1, y2;
    int acks, vlds;
    logic got2;

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack", nnp_ack, 1'b0);
        chk("rst_vld", nnp_vld, 1'b0);
        chk("rst_err", nnp_err, 1'b0);
        chk("rst_res", res_data1 | res_data2 | res_data3, 16'h0);
        chk("rst_drop", wgt_drop, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Identity pass-through on reset weights.
        run_req(8'd2, 16'h0100, 16'hFF00, 16'h7FFF, 0, 0, y0, y1, y2);
        chk("ident_y0", y0, 16'h0100);
        chk("ident_y1", y1, 16'hFF00);
        chk("ident_y2", y2, 16'h7FFF);

        // Write during MAC must be dropped; type-1 weights stay identity.
        run_req(8'd1, 16'($urandom), 16'($urandom), 16'($urandom), 4, 0, y0, y1, y2);
        run_req(8'd1, 16'($urandom), 16'($urandom), 16'($urandom), 0, 0, y0, y1, y2);

        // Programmed weights and bias.
        wr(5'd0, 16'h0080); wr(5'd1, 16'h0080); wr(5'd2, 16'h0000); wr(5'd3, 16'h0100);
        run_req(8'd1, 16'h0200, 16'h0400, 16'h0000, 0, 0, y0, y1, y2);
        chk("prog_y0", y0, 16'h0400);

        // Random type-1 weights against the model.
        for (int k = 0; k < 3; k++)
            for (int j = 0; j < 4; j++)
                wr({1'b0, 2'(k), 2'(j)}, 16'($urandom));
        for (int n = 0; n < 4; n++)
            run_req(8'd1, 16'($urandom), 16'($urandom), 16'($urandom), 0, 0, y0, y1, y2);

        // Large type-2 weights: saturation or wrap.
        for (int k = 0; k < 3; k++)
            for (int j = 0; j < 3; j++)
                wr({1'b1, 2'(k), 2'(j)}, 16'h7FFF);
        run_req(8'd2, 16'h7FFF, 16'h7FFF, 16'h7FFF, 0, 0, y0, y1, y2);
`ifdef NNP_RESP_SAT_EN
        chk("sat_pos", y0, 16'h7FFF);
`endif
        run_req(8'd2, 16'h8001, 16'h8001, 16'h8001, 0, 0, y0, y1, y2);
`ifdef NNP_RESP_SAT_EN
        chk("sat_neg", y1, 16'h8000);
`endif

        // Unsupported type.
        run_req(8'd5, 16'h1111, 16'h2222, 16'h3333, 0, 0, y0, y1, y2);

        // Held request: exactly one ack and one result.
        @(negedge clk);
        nnp_type = 8'd2; req_data1 = 16'h0100; req_data2 = 16'h0200; req_data3 = 16'h0300;
        nnp_req = 1'b1; acks = 0; vlds = 0;
        repeat (40) begin
            @(posedge clk); #1;
            acks += int'(nnp_ack); vlds += int'(nnp_vld);
        end
        chk("hold_acks", acks, 1);
        chk("hold_vlds", vlds, 1);
        @(negedge clk); nnp_req = 1'b0;
        @(negedge clk); nnp_req = 1'b1;
        got2 = 1'b0;
        for (int i = 0; i < 5 && !got2; i++) begin
            @(posedge clk); #1;
            if (nnp_ack) got2 = 1'b1;
        end
        chk("rearm_ack", got2, 1'b1);
        @(negedge clk); nnp_req = 1'b0; vlds = 0;
        repeat (20) begin
            @(posedge clk); #1;
            vlds += int'(nnp_vld);
        end
        chk("rearm_vld", vlds, 1);

        // Reset mid-computation discards the result and restores weights.
        run_req(8'd1, 16'($urandom), 16'($urandom), 16'($urandom), 0, 5, y0, y1, y2);
        model_reset();
        run_req(8'd1, 16'($urandom), 16'($urandom), 16'($urandom), 0, 0, y0, y1, y2);
        run_req(8'd2, 16'($urandom), 16'($urandom), 16'($urandom), 0, 0, y0, y1, y2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
